// File: rtl/sd_spi_card_responder.sv
// Card-side SPI-mode SD responder: oversamples host SCLK/CS/MOSI on clk_clk, decodes
// 6-byte command frames, answers R1/R3/R7 and serves CMD17 reads from a generated pattern.
module sd_spi_card_responder #(
  parameter int INIT_POLLS = 2,
  parameter int ACCESS_GAP = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       sd_card_i_SD_clock,
  input  logic       sd_card_i_SD_dat3,
  input  logic       sd_card_i_SD_cmd,
  output logic       sd_card_o_SD_dat,
  output logic       sd_card_o_SD_dat_oe,
  output logic       cmd_strobe,
  output logic [5:0] cmd_index,
  output logic       card_ready,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_NCR, S_RESP, S_GAP, S_TOKEN, S_DATA, S_CRC
  } state_t;

  localparam logic [9:0] GAP_LAST    = (ACCESS_GAP == 0) ? 10'd0 : 10'(ACCESS_GAP - 1);
  localparam logic [7:0] INIT_POLLS_B = 8'(INIT_POLLS);

  state_t      state, state_nxt;
  logic [1:0]  sclk_s, cs_s, mosi_s;
  logic        sclk_d;
  logic        sclk_rise, sclk_fall, cs_active, byte_done;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [9:0]  cnt;
  logic [5:0]  idx_buf;
  logic [7:0]  arg_lo;
  logic [39:0] resp_sh;
  logic [2:0]  resp_last;
  logic        read_go;
  logic        app_cmd;
  logic [7:0]  polls;
  logic [7:0]  tx_reg, tx_next, tx_byte;
  logic        load_pend;

  // Decoder results, committed when the CRC byte of a frame completes
  logic [39:0] d_resp;
  logic [2:0]  d_last;
  logic        d_read, d_ready, idle_bit;
  logic [7:0]  d_polls, polls_inc;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_s <= 2'b00;
      sclk_d <= 1'b0;
      cs_s   <= 2'b11;
      mosi_s <= 2'b11;
    end else begin
      sclk_s <= {sclk_s[0], sd_card_i_SD_clock};
      sclk_d <= sclk_s[1];
      cs_s   <= {cs_s[0], sd_card_i_SD_dat3};
      mosi_s <= {mosi_s[0], sd_card_i_SD_cmd};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign cs_active = ~cs_s[1];
  assign rx_byte   = {rx_shift, mosi_s[1]};
  assign byte_done = cs_active & sclk_rise & (bit_cnt == 3'd7);

  assign sd_card_o_SD_dat = tx_reg[7];
  assign fsm_state        = state;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)     state <= S_IDLE;
    else if (!cs_active) state <= S_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_done) begin
      case (state)
        S_IDLE:  if (rx_byte[7:6] == 2'b01) state_nxt = S_CMD;
        S_CMD:   if (cnt == 10'd4) state_nxt = S_NCR;
        S_NCR:   state_nxt = S_RESP;
        S_RESP:  if (cnt == {7'd0, resp_last})
                   state_nxt = !read_go ? S_IDLE : ((ACCESS_GAP == 0) ? S_TOKEN : S_GAP);
        S_GAP:   if (cnt == GAP_LAST) state_nxt = S_TOKEN;
        S_TOKEN: state_nxt = S_DATA;
        S_DATA:  if (cnt == 10'd511) state_nxt = S_CRC;
        S_CRC:   if (cnt == 10'd1) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Byte each state hands to the shifter for the next byte slot on the wire
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      S_RESP:  tx_byte = resp_sh[39:32];
      S_TOKEN: tx_byte = 8'hFE;
      S_DATA:  tx_byte = arg_lo + cnt[7:0];
      default: tx_byte = 8'hFF;
    endcase
  end

  always_comb begin
    idle_bit  = ~card_ready;
    d_resp    = {7'd0, idle_bit, 32'hFFFF_FFFF};
    d_last    = 3'd0;
    d_read    = 1'b0;
    d_ready   = card_ready;
    d_polls   = polls;
    polls_inc = (polls == 8'hFF) ? polls : polls + 8'd1;
    case (idx_buf)
      6'd0: begin
        d_resp  = {8'h01, 32'hFFFF_FFFF};
        d_ready = 1'b0;
        d_polls = 8'd0;
      end
      6'd8: begin
        d_resp = {7'd0, idle_bit, 8'h00, 8'h00, 8'h01, arg_lo};
        d_last = 3'd4;
      end
      6'd55: d_resp = {7'd0, idle_bit, 32'hFFFF_FFFF};
      6'd41: begin
        if (app_cmd) begin
          d_polls = polls_inc;
          if (polls_inc >= INIT_POLLS_B) begin
            d_ready = 1'b1;
            d_resp  = {8'h00, 32'hFFFF_FFFF};
          end else begin
            d_resp  = {8'h01, 32'hFFFF_FFFF};
          end
        end else begin
          d_resp = {5'd0, 1'b1, 1'b0, idle_bit, 32'hFFFF_FFFF};
        end
      end
      6'd58: begin
        d_resp = {7'd0, idle_bit, 8'hC0, 8'hFF, 8'h80, 8'h00};
        d_last = 3'd4;
      end
      6'd17: begin
        if (card_ready) begin
          d_resp = {8'h00, 32'hFFFF_FFFF};
          d_read = 1'b1;
        end else begin
          d_resp = {8'h05, 32'hFFFF_FFFF};
        end
      end
      default: d_resp = {5'd0, 1'b1, 1'b0, idle_bit, 32'hFFFF_FFFF};
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bit_cnt             <= 3'd0;
      rx_shift            <= 7'd0;
      cnt                 <= 10'd0;
      idx_buf             <= 6'd0;
      arg_lo              <= 8'd0;
      resp_sh             <= 40'hFF_FFFF_FFFF;
      resp_last           <= 3'd0;
      read_go             <= 1'b0;
      app_cmd             <= 1'b0;
      polls               <= 8'd0;
      card_ready          <= 1'b0;
      cmd_strobe          <= 1'b0;
      cmd_index           <= 6'd0;
      tx_reg              <= 8'hFF;
      tx_next             <= 8'hFF;
      load_pend           <= 1'b0;
      sd_card_o_SD_dat_oe <= 1'b0;
    end else begin
      cmd_strobe          <= 1'b0;
      sd_card_o_SD_dat_oe <= cs_active;
      if (!cs_active) begin
        bit_cnt   <= 3'd0;
        cnt       <= 10'd0;
        tx_reg    <= 8'hFF;
        load_pend <= 1'b0;
        app_cmd   <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          tx_next   <= tx_byte;
          load_pend <= 1'b1;
          cnt       <= (state_nxt != state) ? 10'd0 : cnt + 10'd1;
          if (state == S_IDLE && state_nxt == S_CMD) idx_buf <= rx_byte[5:0];
          if (state == S_CMD && cnt == 10'd3) arg_lo <= rx_byte;
          if (state == S_CMD && cnt == 10'd4) begin
            cmd_strobe <= 1'b1;
            cmd_index  <= idx_buf;
            resp_sh    <= d_resp;
            resp_last  <= d_last;
            read_go    <= d_read;
            card_ready <= d_ready;
            polls      <= d_polls;
            app_cmd    <= (idx_buf == 6'd55);
          end
          if (state == S_RESP) resp_sh <= {resp_sh[31:0], 8'hFF};
        end
        if (sclk_fall) begin
          load_pend <= 1'b0;
          tx_reg    <= load_pend ? tx_next : {tx_reg[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: drives an SPI host at the minimum SCLK half-period and
// checks MISO bytes, strobes and card state against a command-level card model.
module tb_sd_spi_card_responder;
  localparam int INIT_POLLS = 2;
  localparam int ACCESS_GAP = 2;
  localparam int HALF       = 4;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi;
  logic       miso, miso_oe, cmd_strobe, card_ready;
  logic [5:0] cmd_index;
  logic [2:0] fsm_state;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  bit m_ready;
  int m_polls;
  bit m_app;

  sd_spi_card_responder #(.INIT_POLLS(INIT_POLLS), .ACCESS_GAP(ACCESS_GAP)) dut (
    .clk_clk             (clk),
    .reset_reset         (rst),
    .sd_card_i_SD_clock  (sclk),
    .sd_card_i_SD_dat3   (cs),
    .sd_card_i_SD_cmd    (mosi),
    .sd_card_o_SD_dat    (miso),
    .sd_card_o_SD_dat_oe (miso_oe),
    .cmd_strobe          (cmd_strobe),
    .cmd_index           (cmd_index),
    .card_ready          (card_ready),
    .fsm_state           (fsm_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_strobe === 1'b1) strobe_cnt++;

  task automatic check1(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      mosi = tx[b];
      repeat (HALF) @(negedge clk);
      rx[b] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_set(input logic v);
    @(negedge clk);
    cs = v;
    repeat (6) @(negedge clk);
  endtask

  // Card model: expected MISO bytes from byte offset 6 onward, plus state bookkeeping
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] ib;
    logic [7:0] d;
    ib = m_ready ? 8'h00 : 8'h01;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    case (idx)
      6'd0: begin exp_q.push_back(8'h01); m_ready = 0; m_polls = 0; end
      6'd8: begin
        exp_q.push_back(ib); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(arg[7:0]);
      end
      6'd55: exp_q.push_back(ib);
      6'd41: begin
        if (m_app) begin
          m_polls++;
          if (m_polls >= INIT_POLLS) begin m_ready = 1; exp_q.push_back(8'h00); end
          else exp_q.push_back(8'h01);
        end else exp_q.push_back(8'h04 | ib);
      end
      6'd58: begin
        exp_q.push_back(ib); exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80); exp_q.push_back(8'h00);
      end
      6'd17: begin
        if (m_ready) begin
          exp_q.push_back(8'h00);
          for (int g = 0; g < ACCESS_GAP; g++) exp_q.push_back(8'hFF);
          exp_q.push_back(8'hFE);
          for (int i = 0; i < 512; i++) begin
            d = 8'((int'(arg[7:0]) + i) % 256);
            exp_q.push_back(d);
          end
          exp_q.push_back(8'hFF);
          exp_q.push_back(8'hFF);
        end else exp_q.push_back(8'h05);
      end
      default: exp_q.push_back(8'h04 | ib);
    endcase
    m_app = (idx == 6'd55);
  endtask

  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input int nread);
    logic [7:0] r;
    logic [7:0] e;
    int s0;
    s0 = strobe_cnt;
    model_cmd(idx, arg);
    got_q.delete();
    xfer_byte({2'b01, idx}, r);
    xfer_byte(arg[31:24], r);
    xfer_byte(arg[23:16], r);
    xfer_byte(arg[15:8], r);
    xfer_byte(arg[7:0], r);
    xfer_byte((idx == 6'd0) ? 8'h95 : 8'h87, r);
    for (int i = 0; i < nread; i++) begin
      xfer_byte(8'hFF, r);
      got_q.push_back(r);
    end
    for (int i = 0; i < nread; i++) begin
      e = (i < exp_q.size()) ? exp_q[i] : 8'hFF;
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL %s byte %0d: got %h expected %h", name, i + 6, got_q[i], e);
      end
    end
    check1({name, " strobe_pulses"}, 8'(strobe_cnt - s0), 8'd1);
    check1({name, " cmd_index"}, {2'b00, cmd_index}, {2'b00, idx});
    check1({name, " card_ready"}, {7'd0, card_ready}, {7'd0, m_ready});
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
    m_ready = 0; m_polls = 0; m_app = 0;
    repeat (5) @(negedge clk);
    check1("reset dat", {7'd0, miso}, 8'd1);
    check1("reset dat_oe", {7'd0, miso_oe}, 8'd0);
    check1("reset cmd_strobe", {7'd0, cmd_strobe}, 8'd0);
    check1("reset cmd_index", {2'b00, cmd_index}, 8'd0);
    check1("reset card_ready", {7'd0, card_ready}, 8'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle_bytes();
    logic [7:0] r;
    cs_set(1'b0);
    check1("cs low dat_oe", {7'd0, miso_oe}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      xfer_byte(8'hFF, r);
      check1("idle miso", r, 8'hFF);
    end
    check1("idle no strobe", 8'(strobe_cnt), 8'd0);
  endtask

  task automatic test_cmd8();
    logic [31:0] arg;
    run_cmd("cmd8_1aa", 6'd8, 32'h0000_01AA, 7);
    arg = {20'h0, 4'h1, 8'($urandom_range(0, 255))};
    run_cmd("cmd8_rand", 6'd8, arg, 7);
  endtask

  task automatic test_unknown();
    logic [5:0] idx;
    run_cmd("cmd41_no_app", 6'd41, 32'h4000_0000, 4);
    for (int k = 0; k < 2; k++) begin
      do idx = 6'($urandom_range(1, 63));
      while (idx == 6'd8 || idx == 6'd17 || idx == 6'd41 || idx == 6'd55 || idx == 6'd58);
      run_cmd("unknown_cmd", idx, $urandom, 4);
    end
  endtask

  task automatic test_init();
    run_cmd("cmd55_a", 6'd55, 32'h0, 4);
    run_cmd("acmd41_a", 6'd41, 32'h4000_0000, 4);
    run_cmd("cmd55_b", 6'd55, 32'h0, 4);
    run_cmd("acmd41_b", 6'd41, 32'h4000_0000, 4);
    run_cmd("cmd58_ready", 6'd58, 32'h0, 8);
  endtask

  task automatic test_read();
    run_cmd("cmd17_read", 6'd17, 32'h0000_0010, 2 + 1 + ACCESS_GAP + 1 + 512 + 2 + 2);
  endtask

  task automatic test_abort();
    run_cmd("cmd17_abort", 6'd17, {24'h0, 8'($urandom_range(0, 255))}, 2 + 1 + ACCESS_GAP + 1 + 101);
    cs_set(1'b1);
    check1("abort dat_oe", {7'd0, miso_oe}, 8'd0);
    check1("abort dat", {7'd0, miso}, 8'd1);
    m_app = 0;
    cs_set(1'b0);
    run_cmd("cmd58_after_abort", 6'd58, 32'h0, 8);
  endtask

  task automatic test_back_to_back();
    logic [5:0] opts [3];
    opts[0] = 6'd8; opts[1] = 6'd58; opts[2] = 6'd13;
    for (int k = 0; k < 3; k++)
      run_cmd("b2b_cmd", opts[$urandom_range(0, 2)], $urandom, 7);
  endtask

  task automatic test_reset_mid_read();
    run_cmd("cmd17_pre_reset", 6'd17, 32'h0000_0033, 40);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check1("midreset dat_oe", {7'd0, miso_oe}, 8'd0);
    check1("midreset card_ready", {7'd0, card_ready}, 8'd0);
    check1("midreset dat", {7'd0, miso}, 8'd1);
    m_ready = 0; m_polls = 0; m_app = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check1("post reset dat_oe", {7'd0, miso_oe}, 8'd1);
    run_cmd("cmd58_post_reset", 6'd58, 32'h0, 8);
  endtask

  initial begin
    test_reset();
    test_idle_bytes();
    run_cmd("cmd0", 6'd0, 32'h0, 4);
    test_cmd8();
    run_cmd("cmd17_not_ready", 6'd17, 32'h0000_0010, 8);
    test_unknown();
    test_init();
    test_read();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
